// File: rtl/apb_pkg.sv
// Shared definitions for the APB command master: FSM states, slave count,
// default widths and the slave-select decode.
package apb_pkg;

  localparam int NUM_SLAVES  = 4;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  function automatic logic [NUM_SLAVES-1:0] slave_onehot(input logic [1:0] id);
    logic [NUM_SLAVES-1:0] sel;
    sel     = '0;
    sel[id] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB bus bundle; the master modport is the
// view of the command master, the slave modport the view of its environment.
interface apb_cmd_master_if import apb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [1:0]            cmd_slave;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  logic [NUM_SLAVES-1:0] psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_slave, cmd_addr, cmd_wdata,
    input  rsp_ready, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_slave, cmd_addr, cmd_wdata,
    output rsp_ready, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_timeout_cnt.sv
// ACCESS-cycle counter: cleared when a command is accepted, counts SETUP and
// ACCESS cycles (so it reads 1 in the first ACCESS cycle) and saturates at TIMEOUT.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int              CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             expired_q;
  logic             expired_d;

  // Saturating increment keeps the count pinned at TIMEOUT instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    expired_d = (cnt_d == LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/apb_cmd_master.sv
// Converts single command handshakes into APB SETUP/ACCESS transfers with a
// bounded wait for pready, returning read data or a timeout error.
module apb_cmd_master import apb_pkg::*; #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst_n,
  apb_cmd_master_if.master  bus
);

  apb_state_e            state_q;
  apb_state_e            state_d;

  logic [NUM_SLAVES-1:0] psel_q;
  logic [NUM_SLAVES-1:0] psel_d;
  logic                  penable_q;
  logic                  penable_d;
  logic                  pwrite_q;
  logic                  pwrite_d;
  logic [ADDR_W-1:0]     paddr_q;
  logic [ADDR_W-1:0]     paddr_d;
  logic [DATA_W-1:0]     pwdata_q;
  logic [DATA_W-1:0]     pwdata_d;

  logic                  cmd_ready_q;
  logic                  cmd_ready_d;
  logic                  rsp_valid_q;
  logic                  rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q;
  logic [DATA_W-1:0]     rsp_rdata_d;
  logic                  rsp_err_q;
  logic                  rsp_err_d;

  logic                  accept_s;
  logic                  cnt_clear_s;
  logic                  cnt_enable_s;
  logic                  expired_s;

  assign accept_s     = bus.cmd_valid && cmd_ready_q;
  assign cnt_clear_s  = accept_s;
  assign cnt_enable_s = (state_q == SETUP) || (state_q == ACCESS);

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (cnt_clear_s),
    .enable_i  (cnt_enable_s),
    .expired_o (expired_s)
  );

  // A pready seen in the expiry cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.pready || expired_s) begin
          state_d = RESP;
        end else begin
          state_d = ACCESS;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every bus and response output is computed one cycle ahead and registered.
  always_comb begin
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          psel_d      = slave_onehot(bus.cmd_slave);
          penable_d   = 1'b0;
          pwrite_d    = bus.cmd_write;
          paddr_d     = bus.cmd_addr;
          pwdata_d    = bus.cmd_wdata;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end else begin
          psel_d    = '0;
          penable_d = 1'b0;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (bus.pready) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
          rsp_err_d   = 1'b0;
        end else if (expired_s) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          psel_d    = psel_q;
          penable_d = 1'b1;
        end
      end
      RESP: begin
        psel_d    = '0;
        penable_d = 1'b0;
      end
      default: begin
        psel_d      = '0;
        penable_d   = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
    endcase
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning APB read/write data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 1000, meaning the maximum ACCESS cycles to wait for pready (range 1..65535).
REQ-004 clk  input  1  the single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_slave  input  2  target APB slave id (0..3).
REQ-010 cmd_addr  input  ADDR_W  target register address.
REQ-011 cmd_wdata  input  DATA_W  write data.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-014 rsp_rdata  output  DATA_W  read data (0 for writes and errors).
REQ-015 rsp_err  output  1  transfer timed out.
REQ-016 psel  output  4  one-hot APB select, bit cmd_slave.
REQ-017 penable  output  1  APB enable.
REQ-018 pwrite  output  1  APB direction.
REQ-019 paddr  output  ADDR_W  APB address.
REQ-020 pwdata  output  DATA_W  APB write data.
REQ-021 prdata  input  DATA_W  APB read data from the selected slave.
REQ-022 pready  input  1  APB ready from the selected slave.

Function
REQ-023 The FSM SHALL have states IDLE, SETUP, ACCESS, RESP.
REQ-024 cmd_ready SHALL be 1 only in IDLE.
REQ-025 IDLE->SETUP on cmd_valid&&cmd_ready; cmd_write, cmd_slave, cmd_addr, and cmd_wdata are registered on that edge.
REQ-026 In SETUP (exactly one cycle), psel is one-hot and penable=0; SETUP->ACCESS is unconditional.
REQ-027 In ACCESS, psel is held and penable=1; pwrite, paddr, pwdata, and psel are stable from SETUP through the end of ACCESS.
REQ-028 ACCESS->RESP on pready=1; a read captures prdata on that edge with rsp_err=0.
REQ-029 An ACCESS-cycle counter starts at 1 on the first ACCESS cycle; when it equals TIMEOUT with pready=0, ACCESS->RESP with rsp_err=1 and rsp_rdata=0.
REQ-030 pready sampled 1 in the same cycle the counter reaches TIMEOUT SHALL be treated as success, not timeout.
REQ-031 psel and penable SHALL be 0 in IDLE and RESP.
REQ-032 pready and prdata SHALL be ignored outside ACCESS.
REQ-033 rsp_valid SHALL be 1 only in RESP; rsp_rdata and rsp_err are held stable while rsp_valid=1.
REQ-034 RESP->IDLE on rsp_ready=1; a stalled rsp_ready holds RESP indefinitely.
REQ-035 Minimum latency: accept at edge N, SETUP in cycle N+1, ACCESS in cycle N+2; pready=1 in N+2 gives rsp_valid in N+3, and the next accept is possible at N+4 with rsp_ready=1 at N+3.
REQ-036 Write responses SHALL have rsp_rdata=0.
REQ-037 The counter SHALL be wide enough for TIMEOUT without wrap-around and SHALL clear on entering SETUP.

Reset
REQ-038 On rst_n=0, asynchronously: state=IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0; cmd_ready=1 after release.
REQ-039 Reset mid-transfer SHALL abort with no response generated; the first command after release starts a fresh SETUP.

Structure
REQ-040 Shared package apb_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS/RESP), the slave-count constant 4, and the default width constants.
REQ-041 The timeout counter SHALL be a sub-module apb_timeout_cnt (inputs clear/enable, output expired).
REQ-042 The APB outputs SHALL be registered; no combinational path from pready to psel or penable.

Verification
REQ-043 Write: slave 1, addr 0x10, wdata 0xA5, pready=1 on the first ACCESS cycle -> psel=4'b0010; SETUP 1 cycle; rsp_valid at N+3; rsp_err=0, rsp_rdata=0.
REQ-044 Read: slave 2, addr 0x04, pready after 5 wait cycles, prdata=0x3C -> penable high for 6 cycles, rsp_rdata=0x3C, rsp_err=0.
REQ-045 Timeout: TIMEOUT=8, pready held 0 -> exactly 8 ACCESS cycles; rsp_err=1, rsp_rdata=0; psel=0 in RESP.
REQ-046 Backpressure: rsp_ready=0 for 4 cycles with cmd_valid held -> cmd_ready stays 0 and the response is stable; accept occurs 1 cycle after the handshake.
REQ-047 Reset in ACCESS -> psel, penable, and rsp_valid drop immediately; a post-reset read to slave 0 completes normally.
REQ-048 Boundary: pready=1 in the cycle the counter equals TIMEOUT -> success with rsp_err=0.
